// File: rtl/tdd_frame_sched.sv
// Sample-rate TDD frame scheduler: frame counter, tx/rx window enables and one-shot frame-length adjust.
// Optional rx/tx overlap guard selected by `define TDD_GUARD_EN.
`timescale 1ns/1ps
module tdd_frame_sched #(
  parameter int CNT_W = 24,
  parameter int ADJ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ce,
  input  logic             tdd_mode,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [ADJ_W-1:0] frame_adj,
  input  logic             adj_req,
  input  logic [CNT_W-1:0] tstart,
  input  logic [CNT_W-1:0] tend,
  input  logic [CNT_W-1:0] rstart,
  input  logic [CNT_W-1:0] rend,
  output logic             adj_pending,
  output logic             tx_en,
  output logic             rx_en,
  output logic             frame_sync,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [31:0]      frame_cnt,
  output logic             overlap_err
);
  // Two spare bits so frame_len + adjustment never overflows before clamping.
  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] MIN_LEN = SW'(2);
  localparam logic signed [SW-1:0] MAX_LEN = {2'b00, {CNT_W{1'b1}}};

  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_len_q, cur_len_d;
  logic [ADJ_W-1:0] adj_q, adj_d;
  logic             pend_q, pend_d;
  logic             tx_q, tx_d;
  logic             rx_q, rx_d;
  logic             sync_q, sync_d;
  logic [31:0]      fcnt_q, fcnt_d;

  logic             last_sample;
  logic             load_len;
  logic [SW-1:0]    adj_ext;
  logic signed [SW-1:0] len_sum;
  logic [CNT_W-1:0] next_len;
  logic             tx_win, rx_win;

  function automatic logic in_win(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] e,
                                  input logic [CNT_W-1:0] c);
    return (s <= e) ? ((s <= c) && (c < e)) : ((c >= s) || (c < e));
  endfunction

  // Length of the frame about to start; the latched adjustment applies only when pending.
  always_comb begin
    adj_ext = pend_q ? {{(SW-ADJ_W){adj_q[ADJ_W-1]}}, adj_q} : '0;
    len_sum = $signed({2'b00, frame_len}) + $signed(adj_ext);
    if (len_sum < MIN_LEN)      next_len = CNT_W'(2);
    else if (len_sum > MAX_LEN) next_len = {CNT_W{1'b1}};
    else                        next_len = len_sum[CNT_W-1:0];
  end

  assign last_sample = (cnt_q == cur_len_q - CNT_W'(1));

  always_comb begin
    started_d = started_q;
    cnt_d     = cnt_q;
    cur_len_d = cur_len_q;
    adj_d     = adj_q;
    pend_d    = pend_q;
    sync_d    = 1'b0;
    fcnt_d    = fcnt_q;
    load_len  = 1'b0;
    if (!run) begin
      started_d = 1'b0;
      cnt_d     = '0;
    end else if (ce) begin
      if (!started_q) begin
        started_d = 1'b1;
        cnt_d     = '0;
        sync_d    = 1'b1;
        load_len  = 1'b1;
      end else if (last_sample) begin
        cnt_d     = '0;
        sync_d    = 1'b1;
        fcnt_d    = fcnt_q + 32'd1;
        load_len  = 1'b1;
      end else begin
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
    if (load_len) begin
      cur_len_d = next_len;
      pend_d    = 1'b0;
    end
    // A request on the boundary cycle re-arms for the following boundary.
    if (adj_req) begin
      adj_d  = frame_adj;
      pend_d = 1'b1;
    end
  end

  assign tx_win = in_win(tstart, tend, cnt_d);
  assign rx_win = in_win(rstart, rend, cnt_d);

`ifdef TDD_GUARD_EN
  logic ovl_q, ovl_d;

  always_comb begin
    tx_d  = run & (tdd_mode ? tx_win : 1'b1);
    rx_d  = run & (tdd_mode ? rx_win : 1'b1);
    ovl_d = ovl_q;
    if (run && tdd_mode && tx_win && rx_win) begin
      rx_d  = 1'b0;
      ovl_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovl_q <= 1'b0;
    else     ovl_q <= ovl_d;
  end

  assign overlap_err = ovl_q;
`else
  always_comb begin
    tx_d = run & (tdd_mode ? tx_win : 1'b1);
    rx_d = run & (tdd_mode ? rx_win : 1'b1);
  end

  assign overlap_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      started_q <= 1'b0;
      cnt_q     <= '0;
      cur_len_q <= CNT_W'(2);
      adj_q     <= '0;
      pend_q    <= 1'b0;
      tx_q      <= 1'b0;
      rx_q      <= 1'b0;
      sync_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      started_q <= started_d;
      cnt_q     <= cnt_d;
      cur_len_q <= cur_len_d;
      adj_q     <= adj_d;
      pend_q    <= pend_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sync_q    <= sync_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign adj_pending = pend_q;
  assign tx_en       = tx_q;
  assign rx_en       = rx_q;
  assign frame_sync  = sync_q;
  assign sample_cnt  = cnt_q;
  assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_tdd_frame_sched.sv
// Directed bench for tdd_frame_sched: per-cycle expected {frame_sync, tx_en, rx_en, sample_cnt} queue
// built from the intended frame lengths, plus point checks on counters and flags.
`timescale 1ns/1ps
module tb_tdd_frame_sched;
  localparam int CNT_W = 24;
  localparam int ADJ_W = 16;
  localparam int VW    = CNT_W + 3;
`ifdef TDD_GUARD_EN
  localparam logic GUARD_ON = 1'b1;
`else
  localparam logic GUARD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, run, ce, tdd_mode, adj_req;
  logic [CNT_W-1:0] frame_len, tstart, tend, rstart, rend;
  logic [ADJ_W-1:0] frame_adj;
  logic             adj_pending, tx_en, rx_en, frame_sync, overlap_err;
  logic [CNT_W-1:0] sample_cnt;
  logic [31:0]      frame_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  logic [VW-1:0] exp_q[$];

  tdd_frame_sched #(.CNT_W(CNT_W), .ADJ_W(ADJ_W)) dut (
    .clk(clk), .rst(rst), .run(run), .ce(ce), .tdd_mode(tdd_mode),
    .frame_len(frame_len), .frame_adj(frame_adj), .adj_req(adj_req),
    .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
    .adj_pending(adj_pending), .tx_en(tx_en), .rx_en(rx_en),
    .frame_sync(frame_sync), .sample_cnt(sample_cnt), .frame_cnt(frame_cnt),
    .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  function automatic logic win(input int s, input int e, input int c);
    if (s <= e) return (s <= c) && (c < e);
    return (c >= s) || (c < e);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected outputs once sample k is shown, using the window settings currently driven.
  task automatic push_sample(input int k, input logic sync_bit);
    logic tw, rw, t, r;
    tw = win(int'(tstart), int'(tend), k);
    rw = win(int'(rstart), int'(rend), k);
    t  = tdd_mode ? tw : 1'b1;
    r  = tdd_mode ? rw : 1'b1;
    if (GUARD_ON && tdd_mode && tw && rw) r = 1'b0;
    exp_q.push_back({sync_bit, t, r, CNT_W'(k)});
  endtask

  task automatic push_frame(input int len, input int hold = 0);
    for (int k = 0; k < len; k++) begin
      push_sample(k, k == 0);
      for (int h = 0; h < hold; h++) push_sample(k, 1'b0);
    end
  endtask

  task automatic push_idle();
    exp_q.push_back('0);
  endtask

  task automatic tick();
    logic [VW-1:0] want;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      n_vec++;
      assert ({frame_sync, tx_en, rx_en, sample_cnt} === want) else begin
        n_miss++;
        $error("FAIL vector: got sync/tx/rx=%b%b%b cnt=%0d expected sync/tx/rx=%b cnt=%0d",
               frame_sync, tx_en, rx_en, sample_cnt, want[VW-1:CNT_W], want[CNT_W-1:0]);
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  task automatic stop();
    run = 1'b0;
    push_idle();
    drain();
  endtask

  task automatic adj_scn(input int adj_val, input int len2);
    run = 1'b1;
    push_frame(10); push_frame(len2); push_frame(10);
    run_n(2);
    adj_req = 1'b1; frame_adj = ADJ_W'(adj_val);
    run_n(1);
    adj_req = 1'b0;
    check("adj_pending_set", 32'(adj_pending), 32'd1);
    run_n(7);
    check("adj_pending_hold", 32'(adj_pending), 32'd1);
    run_n(1);
    check("adj_pending_clear", 32'(adj_pending), 32'd0);
    drain();
    stop();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; ce = 1'b1; tdd_mode = 1'b1; adj_req = 1'b0;
    frame_len = 24'd10; frame_adj = '0;
    tstart = 24'd0; tend = 24'd4; rstart = 24'd5; rend = 24'd9;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 32'(sample_cnt), 32'd0);
    check("rst_tx", 32'(tx_en), 32'd0);
    check("rst_rx", 32'(rx_en), 32'd0);
    check("rst_sync", 32'(frame_sync), 32'd0);
    check("rst_fcnt", frame_cnt, 32'd0);
    check("rst_pend", 32'(adj_pending), 32'd0);
    check("rst_ovl", 32'(overlap_err), 32'd0);
    rst = 1'b0;

    // Basic TDD, three frames of 10
    run = 1'b1;
    push_frame(10); push_frame(10); push_frame(10);
    drain();
    check("fcnt_basic", frame_cnt, 32'd2);
    stop();
    check("fcnt_hold_stopped", frame_cnt, 32'd2);

    // Wrapping tx window, empty rx window
    tstart = 24'd8; tend = 24'd2; rstart = 24'd3; rend = 24'd3;
    run = 1'b1;
    push_frame(10); push_frame(10);
    drain();
    stop();

    // Strobe every third clock: 30 clocks per frame, then the next frame_sync
    run = 1'b1;
    push_frame(10, 2);
    push_sample(0, 1'b1);
    for (int i = 0; i <= 30; i++) begin
      ce = (i % 3 == 0);
      tick();
    end
    ce = 1'b1;
    stop();

    tstart = 24'd0; tend = 24'd4; rstart = 24'd5; rend = 24'd9;
    adj_scn(-3, 7);
    adj_scn(-20, 2);

    // Overwrite while pending: only the last value is used
    run = 1'b1;
    push_frame(10); push_frame(15); push_frame(10);
    run_n(2);
    adj_req = 1'b1; frame_adj = ADJ_W'(2);
    run_n(1);
    frame_adj = ADJ_W'(5);
    run_n(1);
    adj_req = 1'b0;
    check("overwrite_pend", 32'(adj_pending), 32'd1);
    drain();
    check("overwrite_done", 32'(adj_pending), 32'd0);
    stop();

    // Request on the wrap cycle lands one frame later
    run = 1'b1;
    push_frame(10); push_frame(10); push_frame(7); push_frame(10);
    run_n(10);
    adj_req = 1'b1; frame_adj = ADJ_W'(-3);
    run_n(1);
    adj_req = 1'b0;
    check("coinc_pend", 32'(adj_pending), 32'd1);
    run_n(9);
    check("coinc_pend_hold", 32'(adj_pending), 32'd1);
    run_n(1);
    check("coinc_pend_clear", 32'(adj_pending), 32'd0);
    drain();
    stop();

    // FDD: both enables follow run
    tdd_mode = 1'b0;
    run = 1'b1;
    push_frame(10);
    drain();
    stop();
    tdd_mode = 1'b1;

    // Mid-frame frame_len change takes effect at the next frame
    run = 1'b1;
    push_frame(10); push_frame(6); push_frame(6);
    run_n(3);
    frame_len = 24'd6;
    drain();
    stop();
    frame_len = 24'd10;

    // Reset mid-frame drops the pending adjustment
    run = 1'b1;
    push_frame(10);
    run_n(2);
    adj_req = 1'b1; frame_adj = ADJ_W'(-3);
    run_n(1);
    adj_req = 1'b0;
    check("pre_rst_pend", 32'(adj_pending), 32'd1);
    run_n(2);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_cnt", 32'(sample_cnt), 32'd0);
    check("midrst_tx", 32'(tx_en), 32'd0);
    check("midrst_rx", 32'(rx_en), 32'd0);
    check("midrst_sync", 32'(frame_sync), 32'd0);
    check("midrst_fcnt", frame_cnt, 32'd0);
    check("midrst_pend", 32'(adj_pending), 32'd0);
    push_frame(10); push_frame(10); push_sample(0, 1'b1);
    drain();
    check("fcnt_after_rst", frame_cnt, 32'd2);
    stop();

    // Overlapping windows
    tstart = 24'd0; tend = 24'd6; rstart = 24'd4; rend = 24'd9;
    run = 1'b1;
    push_frame(10);
    drain();
    check("overlap_err", 32'(overlap_err), 32'(GUARD_ON));
    stop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
